// File: rtl/deit_stream_pkg.sv
// Shared stream-side definitions for the DMA ingress packer and the egress gearbox.
package deit_stream_pkg;

    localparam int AXIS_W = 64;
    localparam int WORD_W = 128;

    typedef enum logic {
        S_LOW  = 1'b0,
        S_HIGH = 1'b1
    } pack_state_e;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with a registered output stage; the level and the
// full flag count the output register, so DEPTH words are held in total.
module sync_fifo_fwft #(
    parameter int WIDTH      = 129,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic                  ready_i,
    output logic [WIDTH-1:0]      rdata_o,
    output logic                  valid_o,
    output logic                  full_o,
    output logic [DEPTH_LOG2:0]   level_o
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [DEPTH_LOG2:0] wptr_q, rptr_q;
    logic [DEPTH_LOG2:0] mem_cnt;
    logic [WIDTH-1:0]    dout_q;
    logic                vld_q;
    logic                wr_en;
    logic                ld_en;

    assign mem_cnt = wptr_q - rptr_q;
    assign level_o = mem_cnt + {{DEPTH_LOG2{1'b0}}, vld_q};
    // level never exceeds DEPTH, so its MSB alone marks full
    assign full_o  = level_o[DEPTH_LOG2];
    assign wr_en   = push_i & ~full_o & ~clear_i;
    assign ld_en   = (mem_cnt != '0) & (~vld_q | ready_i);

    assign rdata_o = dout_q;
    assign valid_o = vld_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q[DEPTH_LOG2-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            dout_q <= '0;
            vld_q  <= 1'b0;
        end else if (clear_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            dout_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            if (wr_en) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (ld_en) begin
                dout_q <= mem_q[rptr_q[DEPTH_LOG2-1:0]];
                vld_q  <= 1'b1;
                rptr_q <= rptr_q + 1'b1;
            end else if (ready_i) begin
                vld_q  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/axis_input_packer.sv
// AXIS ingress: packs 64-bit beat pairs into 128-bit words (first beat low) and
// queues them for the compute-side loader; an odd packet tail is zero-padded.
module axis_input_packer
    import deit_stream_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clear,
    input  logic [AXIS_W-1:0]     s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [WORD_W-1:0]     o_data,
    output logic                  o_last,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DEPTH_LOG2:0]   o_level
);

    pack_state_e         state_q, state_d;
    logic [AXIS_W-1:0]   half_q, half_d;
    logic                run_q;
    logic                fifo_full;
    logic                beat;
    logic                push;
    logic [WORD_W:0]     push_word;
    logic [WORD_W:0]     fifo_rdata;

    // run_q keeps tready low until the first edge after reset release
    assign s_axis_tready = run_q & ~fifo_full & ~i_clear;
    assign beat          = s_axis_tvalid & s_axis_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOW;
            half_q  <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        half_d    = half_q;
        push      = 1'b0;
        push_word = '0;
        if (i_clear) begin
            state_d = S_LOW;
            half_d  = '0;
        end else if (beat) begin
            case (state_q)
                S_LOW: begin
                    if (s_axis_tlast) begin
                        push      = 1'b1;
                        push_word = {1'b1, {AXIS_W{1'b0}}, s_axis_tdata};
                    end else begin
                        half_d  = s_axis_tdata;
                        state_d = S_HIGH;
                    end
                end
                S_HIGH: begin
                    push      = 1'b1;
                    push_word = {s_axis_tlast, s_axis_tdata, half_q};
                    state_d   = S_LOW;
                end
                default: state_d = S_LOW;
            endcase
        end
    end

    sync_fifo_fwft #(
        .WIDTH      (WORD_W + 1),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (i_clear),
        .push_i  (push),
        .wdata_i (push_word),
        .ready_i (i_ready),
        .rdata_o (fifo_rdata),
        .valid_o (o_valid),
        .full_o  (fifo_full),
        .level_o (o_level)
    );

    assign o_data = fifo_rdata[WORD_W-1:0];
    assign o_last = fifo_rdata[WORD_W];

endmodule

// File: tb/tb_axis_input_packer.sv
// Randomized bench for axis_input_packer against a packet-level reference model.
module tb_axis_input_packer;

    localparam int DL = 8;

    typedef struct {
        logic [63:0] d;
        logic        last;
        logic        cw;   // this beat completes a word
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_clear = 1'b0;
    logic [63:0]   tdata = '0;
    logic          tvalid = 1'b0;
    logic          tlast = 1'b0;
    logic          tready;
    logic [127:0]  o_data;
    logic          o_last;
    logic          o_valid;
    logic          i_ready = 1'b0;
    logic [DL:0]   o_level;

    int n_pass = 0;
    int n_chk  = 0;

    beat_t        beat_q[$];
    logic [128:0] exp_q[$];

    axis_input_packer #(.DEPTH_LOG2(DL)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_clear       (i_clear),
        .s_axis_tdata  (tdata),
        .s_axis_tvalid (tvalid),
        .s_axis_tready (tready),
        .s_axis_tlast  (tlast),
        .o_data        (o_data),
        .o_last        (o_last),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_level       (o_level)
    );

    always #5 clk = ~clk;

    // Packet model: beats split into consecutive pairs, first beat low,
    // odd tail padded with zero in the high half, last word carries the end flag.
    task automatic gen_packet(input int len);
        logic [63:0] b[$];
        logic [63:0] d;
        for (int i = 0; i < len; i++) begin
            d = {$urandom(), $urandom()};
            b.push_back(d);
            beat_q.push_back('{d, (i == len - 1), ((i % 2) == 1) || (i == len - 1)});
        end
        for (int i = 0; i < len; i += 2)
            exp_q.push_back({(i + 2 >= len), ((i + 1 < len) ? b[i+1] : 64'h0), b[i]});
    endtask

    // Streams every queued beat with tvalid held high; caller checks ok.
    task automatic fill_stream(input int limit, output bit ok);
        int cyc = 0;
        bit acc;
        while (beat_q.size() > 0 && cyc < limit) begin
            tdata = beat_q[0].d; tlast = beat_q[0].last; tvalid = 1'b1;
            @(negedge clk);
            acc = tready;
            @(posedge clk); #1;
            if (acc) void'(beat_q.pop_front());
            cyc++;
        end
        tvalid = 1'b0; tlast = 1'b0;
        ok = (beat_q.size() == 0);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++; if (tready !== 1'b0) $display("FAIL reset_tready got %0b want 0", tready); else n_pass++;
        n_chk++; if (o_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", o_valid); else n_pass++;
        n_chk++; if (o_data !== 128'h0) $display("FAIL reset_data got %h want 0", o_data); else n_pass++;
        n_chk++; if (o_last !== 1'b0) $display("FAIL reset_last got %0b want 0", o_last); else n_pass++;
        n_chk++; if (o_level !== '0) $display("FAIL reset_level got %0d want 0", o_level); else n_pass++;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        n_chk++; if (tready !== 1'b1) $display("FAIL post_reset_tready got %0b want 1", tready); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_pair();
        bit ok;
        beat_q.push_back('{{16{4'h1}}, 1'b0, 1'b0});
        beat_q.push_back('{{16{4'h2}}, 1'b1, 1'b1});
        fill_stream(20, ok);
        n_chk++; if (!ok) $display("FAIL pair_timeout beats left %0d want 0", beat_q.size()); else n_pass++;
        @(negedge clk);
        n_chk++; if (o_valid !== 1'b0 || o_level !== 9'd1)
            $display("FAIL pair_latency got valid %0b level %0d want 0 1", o_valid, o_level); else n_pass++;
        @(negedge clk);
        n_chk++; if ({o_valid, o_last, o_data} !== {1'b1, 1'b1, {16{4'h2}}, {16{4'h1}}})
            $display("FAIL pair_word got v%0b l%0b %h want v1 l1 %h", o_valid, o_last, o_data, {{16{4'h2}}, {16{4'h1}}});
        else n_pass++;
        i_ready = 1'b1;
        @(posedge clk); #1 i_ready = 1'b0;
        @(negedge clk);
        n_chk++; if (o_valid !== 1'b0 || o_level !== 9'd0)
            $display("FAIL pair_pop got valid %0b level %0d want 0 0", o_valid, o_level); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_odd();
        bit ok;
        int cyc = 0;
        logic [128:0] e;
        beat_q.delete(); exp_q.delete();
        gen_packet(3);
        gen_packet(2);
        fill_stream(40, ok);
        n_chk++; if (!ok) $display("FAIL odd_timeout beats left %0d want 0", beat_q.size()); else n_pass++;
        i_ready = 1'b1;
        while (exp_q.size() > 0 && cyc < 40) begin
            @(negedge clk);
            if (o_valid) begin
                e = exp_q.pop_front();
                n_chk++; if ({o_last, o_data} !== e)
                    $display("FAIL odd_word got %h want %h", {o_last, o_data}, e); else n_pass++;
            end
            cyc++;
        end
        @(posedge clk); #1 i_ready = 1'b0;
        n_chk++; if (exp_q.size() != 0) $display("FAIL odd_drain words left %0d want 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [128:0] e;
        beat_q.delete(); exp_q.delete();
        for (int p = 0; p < 64; p++) gen_packet(8);
        fill_stream(2000, ok);
        n_chk++; if (!ok) $display("FAIL bp_timeout beats left %0d want 0", beat_q.size()); else n_pass++;
        @(negedge clk);
        n_chk++; if (o_level !== 9'd256) $display("FAIL bp_level got %0d want 256", o_level); else n_pass++;
        n_chk++; if (tready !== 1'b0) $display("FAIL bp_tready_full got %0b want 0", tready); else n_pass++;
        i_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            e = exp_q.pop_front();
            n_chk++; if (o_valid !== 1'b1 || {o_last, o_data} !== e)
                $display("FAIL bp_word %0d got v%0b %h want v1 %h", i, o_valid, {o_last, o_data}, e);
            else n_pass++;
            @(negedge clk);
        end
        i_ready = 1'b0;
        n_chk++; if (o_valid !== 1'b0 || o_level !== 9'd0)
            $display("FAIL bp_empty got valid %0b level %0d want 0 0", o_valid, o_level); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int   pushed = 0, popped = 0, cyc = 0, nb = 0, len;
        bit   stall = 1'b0, acc, pop;
        logic [128:0] held = '0, e;
        beat_q.delete(); exp_q.delete();
        while (nb < 1000) begin
            len = $urandom_range(1, 9);
            gen_packet(len);
            nb += len;
        end
        while ((exp_q.size() > 0 || beat_q.size() > 0) && cyc < 30000) begin
            if (!tvalid && beat_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                tvalid = 1'b1; tdata = beat_q[0].d; tlast = beat_q[0].last;
            end
            i_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            n_chk++; if (o_level !== 9'(pushed - popped))
                $display("FAIL rnd_level got %0d want %0d", o_level, pushed - popped); else n_pass++;
            if (stall) begin
                n_chk++; if (o_valid !== 1'b1 || {o_last, o_data} !== held)
                    $display("FAIL rnd_stall_hold got v%0b %h want v1 %h", o_valid, {o_last, o_data}, held);
                else n_pass++;
            end
            acc = tvalid & tready;
            pop = o_valid & i_ready;
            if (pop) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                n_chk++; if ({o_last, o_data} !== e)
                    $display("FAIL rnd_word got %h want %h", {o_last, o_data}, e); else n_pass++;
            end
            stall = o_valid & ~i_ready;
            held  = {o_last, o_data};
            @(posedge clk); #1;
            if (acc) begin
                if (beat_q[0].cw) pushed++;
                void'(beat_q.pop_front());
                tvalid = 1'b0; tlast = 1'b0;
            end
            if (pop) popped++;
            cyc++;
        end
        tvalid = 1'b0; i_ready = 1'b0;
        n_chk++; if (exp_q.size() != 0 || beat_q.size() != 0)
            $display("FAIL rnd_complete words left %0d beats left %0d want 0 0", exp_q.size(), beat_q.size());
        else n_pass++;
    endtask

    task automatic test_full_pop();
        bit ok;
        int cyc = 0;
        logic [128:0] e;
        beat_q.delete(); exp_q.delete();
        for (int p = 0; p < 256; p++) gen_packet(2);
        fill_stream(2000, ok);
        n_chk++; if (!ok || o_level !== 9'd256)
            $display("FAIL fp_fill got ok %0b level %0d want 1 256", ok, o_level); else n_pass++;
        gen_packet(2);
        tdata = beat_q[0].d; tlast = 1'b0; tvalid = 1'b1; i_ready = 1'b1;
        @(negedge clk);
        n_chk++; if (tready !== 1'b0) $display("FAIL fp_tready_full got %0b want 0", tready); else n_pass++;
        e = exp_q.pop_front();
        n_chk++; if (o_valid !== 1'b1 || {o_last, o_data} !== e)
            $display("FAIL fp_head got v%0b %h want v1 %h", o_valid, {o_last, o_data}, e); else n_pass++;
        @(posedge clk); #1 i_ready = 1'b0;
        @(negedge clk);
        n_chk++; if (o_level !== 9'd255 || tready !== 1'b1)
            $display("FAIL fp_after_pop got level %0d tready %0b want 255 1", o_level, tready); else n_pass++;
        @(posedge clk); #1;
        tdata = beat_q[1].d; tlast = 1'b1;
        @(negedge clk);
        n_chk++; if (tready !== 1'b1) $display("FAIL fp_tready_second got %0b want 1", tready); else n_pass++;
        @(posedge clk); #1 tvalid = 1'b0; tlast = 1'b0;
        beat_q.delete();
        @(negedge clk);
        n_chk++; if (o_level !== 9'd256) $display("FAIL fp_refill got %0d want 256", o_level); else n_pass++;
        i_ready = 1'b1;
        while (exp_q.size() > 0 && cyc < 400) begin
            if (o_valid) begin
                e = exp_q.pop_front();
                n_chk++; if ({o_last, o_data} !== e)
                    $display("FAIL fp_order got %h want %h", {o_last, o_data}, e); else n_pass++;
            end
            @(negedge clk);
            cyc++;
        end
        i_ready = 1'b0;
        n_chk++; if (exp_q.size() != 0) $display("FAIL fp_drain words left %0d want 0", exp_q.size()); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_clear();
        bit ok;
        int cyc;
        logic [128:0] e;
        for (int mode = 0; mode < 2; mode++) begin
            beat_q.delete(); exp_q.delete();
            for (int p = 0; p < 5; p++) gen_packet(2);
            beat_q.push_back('{{$urandom(), $urandom()}, 1'b0, 1'b0});
            fill_stream(100, ok);
            exp_q.delete();
            @(negedge clk);
            n_chk++; if (!ok || o_level !== 9'd5)
                $display("FAIL clr%0d_setup got ok %0b level %0d want 1 5", mode, ok, o_level); else n_pass++;
            @(posedge clk); #1;
            if (mode == 0) i_clear = 1'b1; else rst_n = 1'b0;
            @(negedge clk);
            if (mode == 0) begin
                n_chk++; if (tready !== 1'b0) $display("FAIL clr_tready got %0b want 0", tready); else n_pass++;
            end
            @(posedge clk); #1 i_clear = 1'b0; rst_n = 1'b1;
            @(negedge clk);
            n_chk++; if (o_valid !== 1'b0 || o_level !== 9'd0)
                $display("FAIL clr%0d_empty got valid %0b level %0d want 0 0", mode, o_valid, o_level); else n_pass++;
            @(posedge clk); #1;
            gen_packet(2);
            fill_stream(20, ok);
            i_ready = 1'b1;
            cyc = 0;
            while (exp_q.size() > 0 && cyc < 20) begin
                @(negedge clk);
                if (o_valid) begin
                    e = exp_q.pop_front();
                    n_chk++; if ({o_last, o_data} !== e)
                        $display("FAIL clr%0d_word got %h want %h", mode, {o_last, o_data}, e); else n_pass++;
                end
                cyc++;
            end
            @(posedge clk); #1 i_ready = 1'b0;
            n_chk++; if (!ok || exp_q.size() != 0)
                $display("FAIL clr%0d_drain got ok %0b words left %0d want 1 0", mode, ok, exp_q.size()); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_pair();
        test_odd();
        test_backpressure();
        test_random();
        test_full_pop();
        test_clear();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
